// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - value-producer / display-pin bundle for seg_scan_ctrl
interface seg_scan_ctrl_if;
    logic        enable;
    logic [15:0] data;
    logic [3:0]  brightness;
    logic        blank_zeros;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        frame_done;

    modport master (
        output enable, data, brightness, blank_zeros,
        input  anodes, segments, frame_done
    );

    modport slave (
        input  enable, data, brightness, blank_zeros,
        output anodes, segments, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit 7-segment scan controller with blanking, PWM and frame latching
module seg_scan_ctrl #(
    parameter int TICK_DIV    = 1024,
    parameter int BLANK_TICKS = 2
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLANK_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic [BW-1:0] bcnt_q, bcnt_n;
    logic [3:0]    phase_q, phase_n;
    logic [1:0]    idx_q, idx_n;
    logic [15:0]   shadow_q, shadow_n;
    logic          bz_q, bz_n;
    logic [3:0]    bright_q, bright_n;
    logic [3:0]    anodes_q, anodes_n;
    logic [6:0]    segments_q, segments_n;
    logic          frame_done_q, frame_done_n;
    logic          tick;
    logic          supp_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    function automatic logic is_suppressed(input logic [1:0] idx, input logic [15:0] sh, input logic bz);
        logic lead_zero;
        case (idx)
            2'd3:    lead_zero = (sh[15:12] == 4'h0);
            2'd2:    lead_zero = (sh[15:8] == 8'h00);
            2'd1:    lead_zero = (sh[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        return bz && lead_zero;
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_n  = state_q;
        presc_n  = presc_q;
        bcnt_n   = bcnt_q;
        phase_n  = phase_q;
        idx_n    = idx_q;
        shadow_n = shadow_q;
        bz_n     = bz_q;
        bright_n = bright_q;

        if (!bus.enable) begin
            state_n = S_IDLE;
            presc_n = '0;
            bcnt_n  = '0;
            phase_n = 4'd0;
            idx_n   = 2'd3;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n  = S_BLANK;
                    presc_n  = '0;
                    bcnt_n   = '0;
                    phase_n  = 4'd0;
                    idx_n    = 2'd3;
                    shadow_n = bus.data;
                    bz_n     = bus.blank_zeros;
                end
                S_BLANK: begin
                    presc_n = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (bcnt_q == BLANK_LAST) begin
                            state_n  = S_ON;
                            bcnt_n   = '0;
                            phase_n  = 4'd0;
                            bright_n = bus.brightness;
                        end else begin
                            bcnt_n = bcnt_q + BW'(1);
                        end
                    end
                end
                S_ON: begin
                    presc_n = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (phase_q == 4'hF) begin
                            state_n = S_BLANK;
                            phase_n = 4'd0;
                            if (idx_q == 2'd0) begin
                                idx_n    = 2'd3;
                                shadow_n = bus.data;
                                bz_n     = bus.blank_zeros;
                            end else begin
                                idx_n = idx_q - 2'd1;
                            end
                        end else begin
                            phase_n = phase_q + 4'd1;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Outputs are registered from the next-state view so they move on the same edge as the state.
        supp_n       = is_suppressed(idx_n, shadow_n, bz_n);
        anodes_n     = (state_n == S_ON && phase_n < bright_n && !supp_n) ? (4'b0001 << idx_n) : 4'b0000;
        segments_n   = (state_n == S_IDLE || supp_n) ? 7'h00 : seg_decode(shadow_n[{idx_n, 2'b00} +: 4]);
        frame_done_n = (state_n == S_ON) && (idx_n == 2'd0) && (phase_n == 4'hF) && (presc_n == PRESC_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            bcnt_q       <= '0;
            phase_q      <= 4'd0;
            idx_q        <= 2'd3;
            shadow_q     <= 16'h0000;
            bz_q         <= 1'b0;
            bright_q     <= 4'd0;
            anodes_q     <= 4'b0000;
            segments_q   <= 7'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            presc_q      <= presc_n;
            bcnt_q       <= bcnt_n;
            phase_q      <= phase_n;
            idx_q        <= idx_n;
            shadow_q     <= shadow_n;
            bz_q         <= bz_n;
            bright_q     <= bright_n;
            anodes_q     <= anodes_n;
            segments_q   <= segments_n;
            frame_done_q <= frame_done_n;
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.segments   = segments_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl against a frame-position model
module tb_seg_scan_ctrl;
    localparam int TD    = 4;
    localparam int BT    = 1;
    localparam int SLOT  = (BT + 16) * TD;
    localparam int FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   chks = 0;

    seg_scan_ctrl_if u_if();

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_TICKS(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    // Model: position in frame counted from the start edge, plus the values latched at frame/ON starts.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [15:0] m_sh  = 16'h0;
    logic        m_bz  = 1'b0;
    logic [3:0]  m_bq  = 4'h0;
    logic [6:0]  hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    function automatic logic [11:0] model_out();
        int idx, w, k;
        logic supp;
        logic [3:0] nib, an;
        if (!m_run) return 12'h000;
        idx  = 3 - m_t / SLOT;
        w    = m_t % SLOT;
        nib  = 4'((m_sh >> (4 * idx)) & 16'hF);
        supp = m_bz && (idx != 0) && ((m_sh >> (4 * idx)) == 16'h0);
        k    = (w - BT * TD) / TD;
        an   = (w >= BT * TD && k < int'(m_bq) && !supp) ? 4'(1 << idx) : 4'h0;
        return {an, supp ? 7'h00 : hex_tab[nib], (m_t == FRAME - 1)};
    endfunction

    function automatic logic [11:0] dut_out();
        return {u_if.anodes, u_if.segments, u_if.frame_done};
    endfunction

    task automatic model_edge();
        if (rst || !u_if.enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            m_sh  = u_if.data;
            m_bz  = u_if.blank_zeros;
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
                m_sh = u_if.data;
                m_bz = u_if.blank_zeros;
            end
            if (m_t % SLOT == BT * TD) m_bq = u_if.brightness;
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic restart();
        u_if.enable = 1'b0;
        tick_clk();
        u_if.enable = 1'b1;
        tick_clk();
    endtask

    task automatic test_reset();
        chks++;
        if (dut_out() !== 12'h000) begin
            errs++; $display("FAIL reset_async got=%h exp=000", dut_out());
        end
        repeat (3) tick_clk();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            u_if.data       = 16'($urandom);
            u_if.brightness = 4'($urandom);
            u_if.blank_zeros = 1'($urandom);
            tick_clk();
            chks++;
            if (dut_out() !== 12'h000) begin
                errs++; $display("FAIL idle_dark i=%0d got=%h exp=000", i, dut_out());
            end
        end
    endtask

    task automatic test_basic_scan();
        int hi [4] = '{0, 0, 0, 0};
        int fd_n = 0, fd_last = 0;
        logic [6:0] seg_tab [4] = '{7'h33, 7'h79, 7'h6D, 7'h30};
        u_if.data = 16'h1234; u_if.brightness = 4'd15; u_if.blank_zeros = 1'b0;
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL basic t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            for (int d = 0; d < 4; d++) begin
                if (u_if.anodes === 4'(1 << d)) begin
                    hi[d]++;
                    chks++;
                    if (u_if.segments !== seg_tab[d]) begin
                        errs++; $display("FAIL basic_seg d=%0d got=%h exp=%h", d, u_if.segments, seg_tab[d]);
                    end
                end
            end
            if (u_if.frame_done === 1'b1) begin
                if (fd_n > 0) begin
                    chks++;
                    if (i - fd_last != FRAME) begin
                        errs++; $display("FAIL basic_fd_gap got=%0d exp=%0d", i - fd_last, FRAME);
                    end
                end
                fd_last = i;
                fd_n++;
            end
        end
        for (int d = 0; d < 4; d++) begin
            chks++;
            if (hi[d] != 2 * 15 * TD) begin
                errs++; $display("FAIL basic_on_time d=%0d got=%0d exp=%0d", d, hi[d], 2 * 15 * TD);
            end
        end
        chks++;
        if (fd_n != 2) begin
            errs++; $display("FAIL basic_fd_count got=%0d exp=2", fd_n);
        end
    endtask

    task automatic test_pwm();
        int on_n = 0, fd_n = 0;
        u_if.brightness = 4'd4;
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME) begin
                chks++;
                if (on_n != 4 * 4 * TD) begin
                    errs++; $display("FAIL pwm4_on got=%0d exp=%0d", on_n, 4 * 4 * TD);
                end
                on_n = 0;
                u_if.brightness = 4'd0;
            end
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL pwm t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            if (u_if.anodes !== 4'h0) on_n++;
            if (i >= FRAME && u_if.frame_done === 1'b1) fd_n++;
        end
        chks++;
        if (on_n != 0 || fd_n != 1) begin
            errs++; $display("FAIL pwm0 on=%0d fd=%0d exp on=0 fd=1", on_n, fd_n);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            u_if.brightness = 4'($urandom);
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL pwm_rand t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
        end
    endtask

    task automatic test_zero_suppress();
        int lit [4] = '{0, 0, 0, 0};
        int lit0 = 0;
        u_if.data = 16'h0070; u_if.blank_zeros = 1'b1; u_if.brightness = 4'd15;
        restart();
        for (int i = 0; i < FRAME; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL supp t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            for (int d = 0; d < 4; d++) if (u_if.anodes[d] === 1'b1) lit[d]++;
            if (u_if.anodes === 4'b0010 && u_if.segments !== 7'h70) begin
                errs++; $display("FAIL supp_seg1 got=%h exp=70", u_if.segments);
            end
        end
        chks++;
        if (lit[3] != 0 || lit[2] != 0 || lit[1] != 15 * TD || lit[0] != 15 * TD) begin
            errs++; $display("FAIL supp_lit got=%0d,%0d,%0d,%0d exp=0,0,60,60", lit[3], lit[2], lit[1], lit[0]);
        end
        u_if.data = 16'h0000;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL supp0 t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            if (i >= FRAME && u_if.anodes !== 4'h0) begin
                if (u_if.anodes === 4'b0001 && u_if.segments === 7'h7E) lit0++;
                else begin
                    errs++; $display("FAIL supp0_lit an=%b seg=%h exp an=0001 seg=7E", u_if.anodes, u_if.segments);
                end
            end
        end
        chks++;
        if (lit0 != 15 * TD) begin
            errs++; $display("FAIL supp0_on got=%0d exp=%0d", lit0, 15 * TD);
        end
    endtask

    task automatic test_frame_latch();
        logic [6:0] tab_old [4] = '{7'h33, 7'h79, 7'h6D, 7'h30};
        logic [6:0] tab_new [4] = '{7'h3D, 7'h4E, 7'h1F, 7'h77};
        logic [6:0] want;
        u_if.data = 16'h1234; u_if.blank_zeros = 1'b0; u_if.brightness = 4'd15;
        restart();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == SLOT + 10) u_if.data = 16'hABCD;
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL latch t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            for (int d = 0; d < 4; d++) begin
                if (u_if.anodes === 4'(1 << d)) begin
                    want = (i < FRAME) ? tab_old[d] : tab_new[d];
                    chks++;
                    if (u_if.segments !== want) begin
                        errs++; $display("FAIL latch_seg i=%0d d=%0d got=%h exp=%h", i, d, u_if.segments, want);
                    end
                end
            end
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                u_if.data        = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                u_if.blank_zeros = 1'($urandom);
                u_if.brightness  = 4'($urandom);
            end
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL latch_rand t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
        end
    endtask

    task automatic test_abort();
        int first_i = -1;
        logic [3:0] first_an = 4'h0;
        u_if.data = 16'h1234; u_if.blank_zeros = 1'b0; u_if.brightness = 4'd15;
        restart();
        for (int i = 0; i < SLOT + BT * TD + 6; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL abort_pre t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
        end
        u_if.enable = 1'b0;
        tick_clk();
        chks++;
        if (dut_out() !== 12'h000) begin
            errs++; $display("FAIL abort_zero got=%h exp=000", dut_out());
        end
        repeat (5) tick_clk();
        u_if.enable = 1'b1;
        for (int i = 0; i < 2 * FRAME - 1; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL abort_re t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
            if (first_i < 0 && u_if.anodes !== 4'h0) begin
                first_i  = i;
                first_an = u_if.anodes;
            end
        end
        chks++;
        if (first_i != BT * TD || first_an !== 4'b1000) begin
            errs++; $display("FAIL abort_restart got=%0d/%b exp=%0d/1000", first_i, first_an, BT * TD);
        end
        u_if.enable = 1'b0;
        tick_clk();
        chks++;
        if (u_if.frame_done !== 1'b0 || dut_out() !== 12'h000) begin
            errs++; $display("FAIL abort_fd got=%h exp=000", dut_out());
        end
        u_if.enable = 1'b1;
        for (int i = 0; i < BT * TD + 4; i++) tick_clk();
        chks++;
        if (u_if.anodes !== 4'b1000) begin
            errs++; $display("FAIL rst_pre got=%b exp=1000", u_if.anodes);
        end
        #2 rst = 1'b1;
        m_run = 1'b0;
        #1;
        chks++;
        if (dut_out() !== 12'h000) begin
            errs++; $display("FAIL rst_mid got=%h exp=000", dut_out());
        end
        repeat (3) tick_clk();
        rst = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick_clk();
            chks++;
            if (dut_out() !== model_out()) begin
                errs++; $display("FAIL rst_post t=%0d got=%h exp=%h", m_t, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        u_if.enable      = 1'b0;
        u_if.data        = 16'h0000;
        u_if.brightness  = 4'd0;
        u_if.blank_zeros = 1'b0;
        #1;
        test_reset();
        test_basic_scan();
        test_pwm();
        test_zero_suppress();
        test_frame_latch();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
